bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_rr_pick.sv | 19 +
 rtl/bus_arbiter.sv | 133 +++++++++++++
 tb/tb_bus_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// State encoding is one-hot so each state decodes from a single flop.
package bus_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int CPU = 0;
    localparam int DMA = 1;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        TW   = 6'b001000,
        T3   = 6'b010000,
        T4   = 6'b100000
    } state_t;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin pick between the CPU and DMA requesters.
// On a tie the master that was not granted last wins; a lone requester always wins.
module bus_rr_pick
    import bus_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last,
    output logic [NUM_MASTERS-1:0] win
);

    always_comb begin
        win = req;
        if (req == {NUM_MASTERS{1'b1}}) begin
            win = '0;
            win[last ? CPU : DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Bus arbiter and T1/T2/TW/T3/T4 bus-cycle sequencer with registered outputs.
// Define BUS_ARB_TIMEOUT_EN to abort a cycle with err after WAIT_MAX wait states.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int WAIT_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] rw,
    input  logic [NUM_MASTERS-1:0] io_sel,
    input  logic                   ready,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic                   ale,
    output logic                   io,
    output logic                   rd_n,
    output logic                   wr_n,
    output logic [NUM_MASTERS-1:0] done,
    output logic                   err,
    output logic                   busy
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t                   state;
    logic                     last;
    logic                     lat_rw;
    logic [CNT_W-1:0]         wait_cnt;
    logic [NUM_MASTERS-1:0]   win;

    bus_rr_pick u_pick (
        .req  (req),
        .last (last),
        .win  (win)
    );

    // Outputs are registered together with the state, so each output
    // reflects the state the sequencer has just entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ale      <= 1'b0;
            io       <= 1'b0;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            done     <= '0;
            busy     <= 1'b0;
            wait_cnt <= '0;
            last     <= 1'b1;
            lat_rw   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            err      <= 1'b0;
`endif
        end else begin
            ale  <= 1'b0;
            done <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        state  <= T1;
                        gnt    <= win;
                        io     <= |(io_sel & win);
                        lat_rw <= |(rw & win);
                        last   <= win[DMA];
                        ale    <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                T1: begin
                    state <= T2;
                    rd_n  <= ~lat_rw;
                    wr_n  <= lat_rw;
                end
                T2: begin
                    if (ready) begin
                        state <= T3;
                        rd_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        done  <= gnt;
                    end else begin
                        state    <= TW;
                        wait_cnt <= '0;
                    end
                end
                TW: begin
                    if (ready) begin
                        state <= T3;
                        rd_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        done  <= gnt;
`ifdef BUS_ARB_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                        state <= T3;
                        rd_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        done  <= gnt;
                        err   <= 1'b1;
`endif
                    end else if (wait_cnt != CNT_W'(WAIT_MAX)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                T3: begin
                    state <= T4;
                end
                T4: begin
                    state <= IDLE;
                    gnt   <= '0;
                    io    <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    io    <= 1'b0;
                    rd_n  <= 1'b1;
                    wr_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef BUS_ARB_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random transfers
// compared cycle by cycle against a transaction-level timing model.
module tb_bus_arbiter;

    localparam int WAIT_MAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] rw;
    logic [1:0] io_sel;
    logic       ready;
    logic [1:0] gnt;
    logic       ale;
    logic       io;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] done;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int lastWin = 1;

    bus_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .rw     (rw),
        .io_sel (io_sel),
        .ready  (ready),
        .gnt    (gnt),
        .ale    (ale),
        .io     (io),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .done   (done),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Expected outputs c cycles after req was presented, for a transfer with
    // k wait states: T1 at 1, strobe 2..2+k, T3 at 3+k, T4 at 4+k, idle after.
    function automatic logic [9:0] expVec(int c, int k, int win, bit rdDir, bit ioSp, bit tout);
        logic [1:0] oh;
        bit         inCycle;
        bit         strobe;
        bit         isT3;
        oh      = (win == 1) ? 2'b10 : 2'b01;
        inCycle = (c >= 1) && (c <= 4 + k);
        strobe  = (c >= 2) && (c <= 2 + k);
        isT3    = (c == 3 + k);
        return {inCycle ? oh : 2'b00,
                (c == 1),
                inCycle ? ioSp : 1'b0,
                !(strobe && rdDir),
                !(strobe && !rdDir),
                isT3 ? oh : 2'b00,
                isT3 && tout,
                inCycle};
    endfunction

    task automatic checkOutput(string tag, logic [9:0] exp);
        logic [9:0] obs;
        obs = {gnt, ale, io, rd_n, wr_n, done, err, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed gnt,ale,io,rd_n,wr_n,done,err,busy=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Runs one transfer starting at a falling edge in IDLE. abortAt > 0 asserts
    // rst after checking that cycle and expects a clean return to IDLE.
    task automatic applyStimulus(string tag, logic [1:0] r, logic [1:0] d, logic [1:0] s,
                                 int k, bit tout, int abortAt);
        int win;
        bit rdDir;
        bit ioSp;
        int last;
        req    = r;
        rw     = d;
        io_sel = s;
        ready  = 1'($urandom);
        if (r == 2'b00) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " idle"}, expVec(0, 0, 0, 1'b0, 1'b0, 1'b0));
            return;
        end
        if (r == 2'b11) win = 1 - lastWin;
        else            win = (r == 2'b10) ? 1 : 0;
        lastWin = win;
        rdDir   = d[win];
        ioSp    = s[win];
        last    = (abortAt > 0) ? abortAt : 5 + k;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("%s c%0d", tag, c), expVec(c, k, win, rdDir, ioSp, tout));
            req    = 2'($urandom);
            rw     = 2'($urandom);
            io_sel = 2'($urandom);
            if (c < 2 || c > 2 + k) ready = 1'($urandom);
            else if (tout)          ready = 1'b0;
            else                    ready = (c >= 2 + k);
        end
        if (abortAt > 0) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " in_reset"}, expVec(0, 0, 0, 1'b0, 1'b0, 1'b0));
            rst = 1'b0;
            req = 2'b00;
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " after_reset"}, expVec(0, 0, 0, 1'b0, 1'b0, 1'b0));
            lastWin = 1;
        end
        req = 2'b00;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 2'b00;
        rw     = 2'b00;
        io_sel = 2'b00;
        ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", expVec(0, 0, 0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_idle", expVec(0, 0, 0, 1'b0, 1'b0, 1'b0));

        applyStimulus("tie1", 2'b11, 2'b11, 2'b00, 0, 1'b0, 0);
        applyStimulus("tie2", 2'b11, 2'b00, 2'b11, 0, 1'b0, 0);
        applyStimulus("tie3", 2'b11, 2'b10, 2'b01, 1, 1'b0, 0);

        applyStimulus("cpu_read", 2'b01, 2'b01, 2'b00, 0, 1'b0, 0);
        applyStimulus("dma_io_write", 2'b10, 2'b00, 2'b10, 3, 1'b0, 0);

`ifdef BUS_ARB_TIMEOUT_EN
        applyStimulus("timeout", 2'b01, 2'b01, 2'b00, WAIT_MAX, 1'b1, 0);
`else
        applyStimulus("long_wait", 2'b01, 2'b01, 2'b00, 25, 1'b0, 0);
`endif

        applyStimulus("reset_in_tw", 2'b10, 2'b10, 2'b00, 10, 1'b0, 3);
        applyStimulus("tie_after_abort", 2'b11, 2'b00, 2'b00, 0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus($sformatf("rand%0d", i), 2'($urandom), 2'($urandom), 2'($urandom),
                          $urandom_range(0, WAIT_MAX - 1), 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
